// File: rtl/data_memory_unit.sv
// Byte-addressable little-endian data memory for the RV32I MEM stage.
// Stores commit on the rising clock edge; loads are combinational with sign/zero extension.
module data_memory_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [2:0]  funct3,
    output logic [31:0] read_data
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0]       mem_r [DEPTH_WORDS];
    logic [ADDR_W-1:0] word_idx_s;
    logic [1:0]        lane_s;
    logic [31:0]       word_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [31:0]       merged_s;
    logic              store_en_s;
    logic [31:0]       rdata_s;
    logic              unused_addr_s;

    // Merge store data into the existing word; halfwords align down to lane 0 or 2.
    function automatic logic [31:0] store_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [2:0]  f3,
        input logic [1:0]  lane
    );
        logic [31:0] merged;
        merged = old_word;
        case (f3)
            F3_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            F3_W:    merged = wdata;
            default: merged = old_word;
        endcase
        return merged;
    endfunction

    // Only SB/SH/SW encodings modify memory.
    function automatic logic is_store_code(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign word_idx_s    = addr[ADDR_W+1:2];
    assign lane_s        = addr[1:0];
    assign unused_addr_s = ^addr[31:ADDR_W+2];
    assign word_s        = mem_r[word_idx_s];
    assign byte_s        = word_s[{lane_s, 3'b000} +: 8];
    assign half_s        = word_s[{lane_s[1], 4'b0000} +: 16];
    assign merged_s      = store_merge(word_s, write_data, funct3, lane_s);
    assign store_en_s    = MemWrite & is_store_code(funct3);

    // Storage array: asynchronous full clear, byte-masked synchronous store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (store_en_s) begin
            mem_r[word_idx_s] <= merged_s;
        end
    end

    // Load path: lane select and extension; reset and disabled reads force zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (MemRead && !rst) begin
            case (funct3)
                F3_B:    rdata_s = {{24{byte_s[7]}}, byte_s};
                F3_BU:   rdata_s = {24'h00_0000, byte_s};
                F3_H:    rdata_s = {{16{half_s[15]}}, half_s};
                F3_HU:   rdata_s = {16'h0000, half_s};
                F3_W:    rdata_s = word_s;
                default: rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign read_data = rdata_s;

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomised bench for data_memory_unit against a byte-array reference model,
// with directed steps pinning literal load results.
module tb_data_memory_unit;

    localparam int DEPTH_WORDS = 256;
    localparam int MEM_BYTES   = DEPTH_WORDS * 4;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [2:0]  funct3;
    logic [31:0] read_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_mem [MEM_BYTES];

    data_memory_unit #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .write_data (write_data),
        .funct3     (funct3),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read();
        int a;
        int hb;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        if (rst || !MemRead) return 32'h0;
        a  = int'(addr % MEM_BYTES);
        hb = a - (a % 2);
        b  = model_mem[a];
        h  = {model_mem[hb + 1], model_mem[hb]};
        w  = {model_mem[a - a % 4 + 3], model_mem[a - a % 4 + 2],
              model_mem[a - a % 4 + 1], model_mem[a - a % 4]};
        case (funct3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            3'b010:  return w;
            default: return 32'h0;
        endcase
    endfunction

    // Reference model state: cleared by reset, updated by stores at the edge.
    always @(posedge clk or posedge rst) begin
        int a;
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
        end else if (MemWrite) begin
            a = int'(addr % MEM_BYTES);
            case (funct3)
                3'b000: model_mem[a] = write_data[7:0];
                3'b001: begin
                    a = a - (a % 2);
                    model_mem[a]     = write_data[7:0];
                    model_mem[a + 1] = write_data[15:8];
                end
                3'b010: begin
                    a = a - (a % 4);
                    for (int k = 0; k < 4; k++) model_mem[a + k] = write_data[8*k +: 8];
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (addr=%08h f3=%0d rd=%0b rst=%0b)",
                     name, act, exp, addr, funct3, MemRead, rst);
        end
    endtask

    // Per-cycle comparison of the DUT load result against the model.
    always @(negedge clk) begin
        if (rst !== 1'bx) chk("model", read_data, model_read());
    end

    task automatic step(input logic r, input logic mr, input logic mw,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        @(posedge clk);
        #1;
        rst = r; MemRead = mr; MemWrite = mw; addr = a; write_data = wd; funct3 = f3;
    endtask

    task automatic lit(input string name, input logic [31:0] exp);
        @(negedge clk);
        #1;
        chk(name, read_data, exp);
    endtask

    initial begin
        rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        addr = 32'h0; write_data = 32'h0; funct3 = 3'b000;
        #1 rst = 1'b1;

        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);          lit("reset_lw0", 32'h0000_0000);
        step(1'b0, 1'b0, 1'b0, 32'h14, 32'h0, 3'b010);         lit("memread_low", 32'h0000_0000);

        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 3'b010);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);          lit("sw_lw", 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 1'b1, 32'h1, 32'h0000_0011, 3'b000);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);          lit("sb_lane1", 32'hDEAD_11EF);

        step(1'b0, 1'b0, 1'b1, 32'h4, 32'h0000_ABCD, 3'b001);
        step(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 3'b001);          lit("lh", 32'hFFFF_ABCD);
        step(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 3'b101);          lit("lhu", 32'h0000_ABCD);
        step(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 3'b010);          lit("lw_after_sh", 32'h0000_ABCD);
        step(1'b0, 1'b1, 1'b0, 32'h5, 32'h0, 3'b001);          lit("lh_misaligned", 32'hFFFF_ABCD);

        step(1'b0, 1'b0, 1'b1, 32'h8, 32'h0000_00AA, 3'b000);
        step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 3'b000);          lit("lb", 32'hFFFF_FFAA);
        step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 3'b100);          lit("lbu", 32'h0000_00AA);
        step(1'b0, 1'b0, 1'b1, 32'h9, 32'h0000_007F, 3'b000);
        step(1'b0, 1'b1, 1'b0, 32'h9, 32'h0, 3'b000);          lit("lb_pos", 32'h0000_007F);

        step(1'b0, 1'b0, 1'b1, 32'h400, 32'h1234_5678, 3'b010);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);          lit("wrap", 32'h1234_5678);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 3'b011);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);          lit("store_011", 32'h1234_5678);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b110);          lit("load_110", 32'h0000_0000);
        step(1'b0, 1'b1, 1'b1, 32'h0, 32'h55AA_55AA, 3'b010);  lit("rw_old", 32'h1234_5678);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);          lit("rw_new", 32'h55AA_55AA);

        step(1'b1, 1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 3'b010);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);          lit("rst_no_write", 32'h0000_0000);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'hA5A5_A5A5, 3'b010);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        #1 chk("pre_async", read_data, 32'hA5A5_A5A5);
        #1 rst = 1'b1;
        #1 chk("async_rst", read_data, 32'h0000_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);          lit("after_async", 32'h0000_0000);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 47));
            step(($urandom_range(0, 99) == 0), 1'($urandom()), 1'($urandom()),
                 a, $urandom(), 3'($urandom_range(0, 7)));
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
Byte-addressable, little-endian data memory for the single-cycle RISC-V core, sitting behind the ALU address path in the MEM stage. Supports RV32I loads (LB, LH, LW, LBU, LHU) and stores (SB, SH, SW) selected by the instruction's funct3. Stores commit synchronously on the rising clock edge. Loads are combinational, so read data is valid in the same cycle as the address.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words (1 KiB); must be a power of two.
ADDR_W, log2(DEPTH_WORDS), word-index width, derived from DEPTH_WORDS.

Ports:
clk  input  1  system clock; rising-edge active.
rst  input  1  asynchronous, active-high reset; clears the entire array.
MemRead  input  1  load enable; when low, read_data is 0.
MemWrite  input  1  store enable; sampled on the rising edge of clk.
addr  input  32  byte address.
write_data  input  32  store data; the low byte/halfword is used for SB/SH.
funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
read_data  output  32  load result, sign- or zero-extended as selected.

Behaviour:
- Storage: DEPTH_WORDS x 32-bit array.
  - Word index = addr[ADDR_W+1:2].
  - Upper address bits are ignored, so addresses wrap modulo memory size.
  - Byte lane b (addr[1:0]=b) occupies bits [8b+7:8b] (little-endian).
- Reset: while rst=1, every word reads 0 and writes are suppressed. Clearing is asynchronous and takes effect immediately, not at the next edge.
- Write on posedge clk, when MemWrite=1 and rst=0:
  - SB (000): write_data[7:0] goes to the lane given by addr[1:0]; other lanes unchanged.
  - SH (001): write_data[15:0] goes to lanes {addr[1],0} and {addr[1],1}; addr[0] is ignored (aligned down); other lanes unchanged.
  - SW (010): the full word is written; addr[1:0] is ignored.
  - Any other funct3: no write.
- Read is combinational:
  - When MemRead=0, read_data = 32'h0.
  - LB (000): the selected byte, sign-extended from bit 7.
  - LBU (100): the selected byte, zero-extended.
  - LH (001): halfword at {addr[1],0}, sign-extended from bit 15.
  - LHU (101): the same halfword, zero-extended.
  - LW (010): the full word.
  - funct3 011/110/111: read_data = 0.
- MemRead and MemWrite both high at the same address: read_data shows the old contents until the edge, then the new contents (no bypass).
- With MemRead=0 and MemWrite=0, memory contents are held indefinitely.
- No misalignment trap is raised; misaligned halfword/word accesses are aligned down silently.
- No read latency; write latency is one edge.

Test Plan:
1. Reset, then MemRead=1, funct3=010, addr=0 -> read_data=32'h00000000; also MemRead=0 at any address -> 0.
2. SW with addr=0, write_data=DEADBEEF, one clock edge; then LW addr=0 -> DEADBEEF. Then SB addr=1, write_data=0x11; LW addr=0 -> DEAD11EF (byte-lane isolation).
3. SH with addr=4, write_data=0000ABCD; then:
   - LH addr=4 -> FFFFABCD
   - LHU addr=4 -> 0000ABCD
   - LW addr=4 -> 0000ABCD
4. SB with addr=8, write_data=000000AA; then:
   - LB addr=8 -> FFFFFFAA
   - LBU addr=8 -> 000000AA
   - SB 0x7F at addr=9, then LB addr=9 -> 0000007F
5. Wrap and unsupported codes:
   - SW with addr=0x400 (DEPTH_WORDS=256), write 12345678; LW addr=0 -> 12345678.
   - Store with funct3=011 -> memory unchanged.
   - Load with funct3=110 -> 0.
6. Reset mid-operation: MemWrite=1, write 0xCAFEF00D to addr=0 with rst asserted across the edge -> no write; after release, LW addr=0 -> 0. Asserting rst between edges zeroes read_data immediately.
